// File: rtl/fasm_fifo_wbw.sv
// Drains a FIFO into one held-CYC Wishbone burst of single writes to incrementing addresses.
// Cmd to first STB is 2 cycles, then 1 word/cycle on a zero-wait slave; a missing word or a stalled slave holds the burst.
module fasm_fifo_wbw #(
  parameter int DW    = 32,
  parameter int ADR_W = 32,
  parameter int LW    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_stb_i,
  input  logic [ADR_W-1:0]  cmd_adr_i,
  input  logic [LW-1:0]     cmd_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic [DW-1:0]     fifo_dat_i,
  input  logic              fifo_rok_i,
  output logic              fifo_rde_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [ADR_W-1:0]  wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  localparam int                BPW      = DW / 8;
  localparam logic [ADR_W-1:0]  ADR_INC  = ADR_W'(BPW);
  localparam logic [ADR_W-1:0]  ADR_MASK = ~ADR_W'(BPW - 1);

  state_t             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DW-1:0]      dat_q, dat_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic               pop;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_stb_i) begin
          adr_d = cmd_adr_i & ADR_MASK;
          cnt_d = cmd_len_i;
          if (cmd_len_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cyc_d   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (fifo_rok_i) begin
          pop     = 1'b1;
          dat_d   = fifo_dat_i;
          stb_d   = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        // Error wins over ack; the faulted word is considered consumed, nothing more is popped.
        if (wb_err_i) begin
          stb_d   = 1'b0;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wb_ack_i) begin
          cnt_d = cnt_q - LW'(1);
          adr_d = adr_q + ADR_INC;
          if (cnt_q == LW'(1)) begin
            stb_d   = 1'b0;
            cyc_d   = 1'b0;
            state_d = DONE;
          end else if (fifo_rok_i) begin
            pop   = 1'b1;
            dat_d = fifo_dat_i;
          end else begin
            stb_d   = 1'b0;
            state_d = WAIT;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign fifo_rde_o = pop;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = stb_q;
  assign wb_sel_o   = {BPW{stb_q}};
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;

endmodule

// File: tb/tb_fasm_fifo_wbw.sv
// Bench for fasm_fifo_wbw: FIFO and Wishbone slave models, write scoreboard, table of burst scenarios.
module tb_fasm_fifo_wbw;

  logic        clk_i, rst_i;
  logic        cmd_stb_i;
  logic [31:0] cmd_adr_i;
  logic [7:0]  cmd_len_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] fifo_dat_i;
  logic        fifo_rok_i, fifo_rde_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        wb_ack_i, wb_err_i;

  fasm_fifo_wbw #(.DW(32), .ADR_W(32), .LW(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_stb_i(cmd_stb_i), .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .fifo_dat_i(fifo_dat_i), .fifo_rok_i(fifo_rok_i), .fifo_rde_o(fifo_rde_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] adr;
    int          len;
    int          npush;
    int          wait_c;
    int          err_idx;
    logic        exp_err;
    int          exp_pops;
    int          exp_wr;
    int          exp_stb;
    int          exp_left;
    int          first_stb;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];

  int   n_pops, n_wr, n_done, n_stb;
  logic last_err;
  int   slave_wait, err_idx, wr_idx, wait_ctr;
  int   cyc_n = 0;
  int   cmd_cyc, first_stb_cyc;
  logic stalled, prev_err;
  logic [31:0] stall_adr, stall_dat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fifo_refresh();
    fifo_rok_i = (fifo_q.size() != 0);
    fifo_dat_i = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_dat.push_back(w);
    fifo_refresh();
  endtask

  task automatic clear_all();
    fifo_q.delete();
    exp_adr.delete();
    exp_dat.delete();
    fifo_refresh();
    n_pops = 0; n_wr = 0; n_done = 0; n_stb = 0; last_err = 1'b0;
    wr_idx = 0; wait_ctr = 0; stalled = 1'b0; prev_err = 1'b0;
  endtask

  task automatic chk_outs_zero(input string nm);
    chk({nm, "_ctl"}, {busy_o, done_o, err_o, fifo_rde_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}, 0);
    chk({nm, "_adr"}, wb_adr_o, 0);
    chk({nm, "_dat"}, wb_dat_o, 0);
  endtask

  // One clock: monitor at the falling edge, then FIFO pop and slave response just after the rising edge.
  task automatic tick();
    logic pop_pend;
    @(negedge clk_i);
    cyc_n++;
    pop_pend = fifo_rde_o;
    if (fifo_rde_o) begin
      n_pops++;
      chk("pop_when_empty", fifo_rok_i, 1);
    end
    if (wb_stb_o) begin
      n_stb++;
      if (first_stb_cyc < 0) first_stb_cyc = cyc_n - cmd_cyc;
    end
    if (stalled) begin
      chk("stall_adr", wb_adr_o, stall_adr);
      chk("stall_dat", wb_dat_o, stall_dat);
    end
    if (prev_err) chk("drop_after_err", {wb_cyc_o, wb_stb_o}, 0);
    if (wb_stb_o && wb_ack_i && !wb_err_i) begin
      n_wr++;
      chk("wr_expected", (exp_adr.size() != 0 && exp_dat.size() != 0), 1);
      if (exp_adr.size() != 0 && exp_dat.size() != 0) begin
        chk("wr_adr", wb_adr_o, exp_adr.pop_front());
        chk("wr_dat", wb_dat_o, exp_dat.pop_front());
        chk("wr_we_sel", {wb_we_o, wb_sel_o}, 5'h1f);
      end
    end
    stalled   = wb_stb_o && !wb_ack_i && !wb_err_i;
    stall_adr = wb_adr_o;
    stall_dat = wb_dat_o;
    prev_err  = wb_stb_o && wb_err_i;
    if (done_o) begin
      n_done++;
      last_err = err_o;
    end
    @(posedge clk_i);
    #1;
    if (pop_pend && fifo_q.size() != 0) void'(fifo_q.pop_front());
    fifo_refresh();
    if (wb_stb_o) begin
      if (wait_ctr >= slave_wait) begin
        wb_err_i = (wr_idx == err_idx);
        wb_ack_i = !wb_err_i;
        wr_idx++;
        wait_ctr = 0;
      end else begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wait_ctr++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wait_ctr = 0;
    end
  endtask

  task automatic wait_done(input string nm);
    for (int c = 0; c < 300 && n_done == 0; c++) tick();
    chk({nm, "_done_seen"}, n_done, 1);
  endtask

  vec_t vecs[7];

  initial begin
    //          adr            len np wt eidx err pops wr stb left 1st
    vecs[0] = '{32'h0000_0100, 4, 4, 0, -1, 1'b0, 4, 4, 4, 0,  2};
    vecs[1] = '{32'h0000_0203, 3, 3, 2, -1, 1'b0, 3, 3, 9, 0,  2};
    vecs[2] = '{32'h0000_0400, 4, 4, 0,  1, 1'b1, 2, 1, 2, 2,  2};
    vecs[3] = '{32'h0000_0500, 0, 1, 0, -1, 1'b0, 0, 0, 0, 1, -1};
    vecs[4] = '{32'hFFFF_FFFC, 2, 2, 0, -1, 1'b0, 2, 2, 2, 0,  2};
    vecs[5] = '{32'h0000_0600, 2, 2, 1,  0, 1'b1, 1, 0, 2, 1,  2};
    vecs[6] = '{32'h0000_0700, 2, 4, 0, -1, 1'b0, 2, 2, 2, 2,  2};

    rst_i = 1'b0;
    cmd_stb_i = 1'b0; cmd_adr_i = 32'h0; cmd_len_i = 8'h0;
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    slave_wait = 0; err_idx = -1; cmd_cyc = 0; first_stb_cyc = -1;
    clear_all();
    tick();
    tick();
    chk_outs_zero("reset");
    rst_i = 1'b1;
    tick();
    chk_outs_zero("idle");

    for (int v = 0; v < 7; v++) begin
      clear_all();
      slave_wait = vecs[v].wait_c;
      err_idx    = vecs[v].err_idx;
      for (int i = 0; i < vecs[v].npush; i++) push_word($urandom);
      for (int i = 0; i < vecs[v].len; i++)
        exp_adr.push_back((vecs[v].adr & 32'hFFFF_FFFC) + 32'(4 * i));
      cmd_adr_i = vecs[v].adr;
      cmd_len_i = 8'(vecs[v].len);
      cmd_stb_i = 1'b1;
      cmd_cyc = cyc_n + 1;
      first_stb_cyc = -1;
      tick();
      cmd_stb_i = 1'b0;
      wait_done($sformatf("v%0d", v));
      chk($sformatf("v%0d_err", v), last_err, vecs[v].exp_err);
      tick();
      tick();
      chk($sformatf("v%0d_pops", v), n_pops, vecs[v].exp_pops);
      chk($sformatf("v%0d_writes", v), n_wr, vecs[v].exp_wr);
      chk($sformatf("v%0d_stb_cycles", v), n_stb, vecs[v].exp_stb);
      chk($sformatf("v%0d_fifo_left", v), fifo_q.size(), vecs[v].exp_left);
      chk($sformatf("v%0d_one_done", v), n_done, 1);
      chk($sformatf("v%0d_idle_after", v), {busy_o, wb_cyc_o, wb_sel_o}, 0);
      if (vecs[v].first_stb >= 0)
        chk($sformatf("v%0d_first_stb", v), first_stb_cyc, vecs[v].first_stb);
    end

    // Zero-length command: done one cycle after the sampling edge, never opens a cycle.
    clear_all();
    slave_wait = 0; err_idx = -1;
    cmd_len_i = 8'h0; cmd_adr_i = 32'h0000_0800; cmd_stb_i = 1'b1;
    tick();
    cmd_stb_i = 1'b0;
    chk("len0_done", {done_o, err_o, wb_cyc_o, fifo_rde_o}, 4'b1000);
    tick();
    chk("len0_done_gone", {done_o, busy_o}, 0);

    // Empty FIFO start, late words, and a command issued while busy that must be dropped.
    clear_all();
    exp_adr.push_back(32'h300);
    exp_adr.push_back(32'h304);
    cmd_adr_i = 32'h300; cmd_len_i = 8'd2; cmd_stb_i = 1'b1;
    tick();
    cmd_stb_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        cmd_stb_i = 1'b1; cmd_adr_i = 32'h900; cmd_len_i = 8'd5;
      end else begin
        cmd_stb_i = 1'b0;
      end
      if (c == 5) push_word(32'hA5A5_0001);
      if (c == 12) push_word(32'hA5A5_0002);
      tick();
      if (c == 4) chk("t3_wait_first", {busy_o, wb_cyc_o, wb_stb_o}, 3'b110);
      if (c == 10) chk("t3_wait_second", {busy_o, wb_cyc_o, wb_stb_o}, 3'b110);
    end
    wait_done("t3");
    for (int c = 0; c < 10; c++) tick();
    chk("t3_writes", n_wr, 2);
    chk("t3_pops", n_pops, 2);
    chk("t3_err", last_err, 0);
    chk("t3_no_second_burst", {n_done[7:0], busy_o, wb_cyc_o}, 10'h004);

    // Reset while a stalled write is on the bus.
    clear_all();
    slave_wait = 5; err_idx = -1;
    for (int i = 0; i < 3; i++) push_word(32'hC0DE_0000 + 32'(i));
    cmd_adr_i = 32'h1000; cmd_len_i = 8'd3; cmd_stb_i = 1'b1;
    tick();
    cmd_stb_i = 1'b0;
    for (int c = 0; c < 20 && !wb_stb_o; c++) tick();
    chk("t6_in_xfer", wb_stb_o, 1);
    tick();
    rst_i = 1'b0;
    stalled = 1'b0;
    #1;
    chk_outs_zero("t6_async");
    tick();
    tick();
    rst_i = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    chk("t6_no_done", n_done, 0);
    chk("t6_idle", {busy_o, wb_cyc_o, fifo_rde_o}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
